// File: rtl/sample_align_delay.sv
// sample_align_delay
//   Runtime-programmable delay line that aligns multi-channel IQ samples with
//   the PSS peak strobe. The delay is counted in valid samples. A one-bit peak
//   tag travels through the buffer alongside the data.
// Ports
//   clk_i, reset_i         clock, async active-high reset
//   s_axis_in_tdata/tvalid NUM_CH lanes of IN_DW-bit samples, no backpressure
//   peak_i                 single-cycle peak strobe (any cycle)
//   delay_i/delay_load_i   runtime delay override (in valid samples)
//   m_axis_out_tdata/tvalid delayed samples, one clock after the input strobe
//   peak_aligned_o         marks the output sample carrying the peak tag
//   primed_o               fill has reached the active delay
//   cfg_err_o              sticky: a load requested delay_i > MAX_DELAY

// Per-lane storage: circular RAM plus a registered output.
module sample_align_lane #(
    parameter int IN_DW = 32,
    parameter int DEPTH = 128,
    parameter int PTR_W = 7
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  logic [IN_DW-1:0] wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    input  logic             out_en,
    input  logic             bypass,
    output logic [IN_DW-1:0] out_data
);
    logic [IN_DW-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Read happens before the write of this cycle; with D >= 1 the read
    // slot never equals the slot being written.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)     out_data <= '0;
        else if (out_en) out_data <= bypass ? wr_data : mem[rd_addr];
    end
endmodule

module sample_align_delay #(
    parameter int IN_DW         = 32,
    parameter int NUM_CH        = 1,
    parameter int MAX_DELAY     = 64,
    parameter int DEFAULT_DELAY = 14
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [NUM_CH*IN_DW-1:0]                s_axis_in_tdata,
    input  logic                                   s_axis_in_tvalid,
    input  logic                                   peak_i,
    input  logic [$clog2(MAX_DELAY+1)-1:0]         delay_i,
    input  logic                                   delay_load_i,
    output logic [NUM_CH*IN_DW-1:0]                m_axis_out_tdata,
    output logic                                   m_axis_out_tvalid,
    output logic                                   peak_aligned_o,
    output logic                                   primed_o,
    output logic                                   cfg_err_o
);
    localparam int DELAY_W = $clog2(MAX_DELAY+1);
    localparam int DEPTH   = 2**$clog2(MAX_DELAY+1);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam logic [DELAY_W-1:0] MAX_D = DELAY_W'(MAX_DELAY);
    localparam logic [DELAY_W-1:0] DEF_D = DELAY_W'(DEFAULT_DELAY);

    logic [PTR_W-1:0]   wr_ptr;
    logic [DELAY_W-1:0] d_q, d_eff;
    logic [DELAY_W-1:0] fill_q, fill_eff, fill_next;
    logic               pending;
    logic               emit, bypass, wr_tag, load_err;
    logic [PTR_W-1:0]   rd_addr;
    logic               tag_mem [DEPTH];

    // A load takes effect on its own cycle: new D and an emptied fill are
    // what this cycle's valid sample sees.
    always_comb begin
        d_eff    = d_q;
        fill_eff = fill_q;
        load_err = 1'b0;
        if (delay_load_i) begin
            load_err = (delay_i > MAX_D);
            d_eff    = load_err ? MAX_D : delay_i;
            fill_eff = '0;
        end
        emit      = s_axis_in_tvalid && (fill_eff >= d_eff);
        bypass    = (d_eff == '0);
        rd_addr   = wr_ptr - PTR_W'(d_eff);
        wr_tag    = pending | peak_i;
        // fill never exceeds D, so stopping at equality is saturation
        fill_next = fill_eff;
        if (s_axis_in_tvalid && (fill_eff != d_eff)) fill_next = fill_eff + 1'b1;
    end

    genvar k;
    generate
        for (k = 0; k < NUM_CH; k++) begin : g_lane
            sample_align_lane #(.IN_DW(IN_DW), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_lane (
                .clk_i    (clk_i),
                .reset_i  (reset_i),
                .wr_en    (s_axis_in_tvalid),
                .wr_addr  (wr_ptr),
                .wr_data  (s_axis_in_tdata[k*IN_DW +: IN_DW]),
                .rd_addr  (rd_addr),
                .out_en   (emit),
                .bypass   (bypass),
                .out_data (m_axis_out_tdata[k*IN_DW +: IN_DW])
            );
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (s_axis_in_tvalid) tag_mem[wr_ptr] <= wr_tag;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr            <= '0;
            d_q               <= DEF_D;
            fill_q            <= '0;
            pending           <= 1'b0;
            m_axis_out_tvalid <= 1'b0;
            peak_aligned_o    <= 1'b0;
            primed_o          <= (DEFAULT_DELAY == 0);
            cfg_err_o         <= 1'b0;
        end else begin
            d_q               <= d_eff;
            fill_q            <= fill_next;
            primed_o          <= (fill_next == d_eff);
            cfg_err_o         <= cfg_err_o | load_err;
            m_axis_out_tvalid <= emit;
            peak_aligned_o    <= emit && (bypass ? wr_tag : tag_mem[rd_addr]);
            // peaks between samples merge into the next written tag
            if (s_axis_in_tvalid) begin
                wr_ptr  <= wr_ptr + 1'b1;
                pending <= 1'b0;
            end else begin
                pending <= pending | peak_i;
            end
        end
    end
endmodule
